// File: rtl/axis_header_arbiter.sv
// Round-robin arbiter feeding one header-insert channel; one grant per packet, held until last_out.
// Optional watchdog enabled by defining HDR_ARB_WDOG_EN.
module axis_header_arbiter #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int NUM_REQ      = 4,
    parameter int REQ_IDX_WD   = $clog2(NUM_REQ),
    parameter int WDOG_CYC     = 1024
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WD-1:0]      req_data,
    input  logic [NUM_REQ*DATA_BYTE_WD-1:0] req_keep,
    input  logic [NUM_REQ*BYTE_CNT_WD-1:0]  req_byte_cnt,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            valid_insert,
    output logic [DATA_WD-1:0]              data_insert,
    output logic [DATA_BYTE_WD-1:0]         keep_insert,
    output logic [BYTE_CNT_WD-1:0]          byte_insert_cnt,
    input  logic                            ready_insert,
    input  logic                            valid_out,
    input  logic                            ready_out,
    input  logic                            last_out,
    output logic                            grant_vld,
    output logic [REQ_IDX_WD-1:0]           grant_idx,
    output logic                            wdog_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFFER,
        ST_BUSY
    } state_e;

    state_e                  state_q, state_d;
    logic [REQ_IDX_WD-1:0]   ptr_q, ptr_d;
    logic [REQ_IDX_WD-1:0]   grant_idx_q, grant_idx_d;
    logic [DATA_WD-1:0]      hold_data_q, hold_data_d;
    logic [DATA_BYTE_WD-1:0] hold_keep_q, hold_keep_d;
    logic [BYTE_CNT_WD-1:0]  hold_cnt_q, hold_cnt_d;

    logic                    win_vld;
    logic [REQ_IDX_WD-1:0]   win_idx;
    logic [REQ_IDX_WD-1:0]   cand;
    logic                    out_beat;
    logic                    pkt_end;
    logic                    wdog_hit;

    assign out_beat = valid_out && ready_out;
    assign pkt_end  = out_beat && last_out;

    // Search starts one past the last grant and wraps modulo NUM_REQ, so non-power-of-2 counts work.
    always_comb begin : p_search
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = REQ_IDX_WD'((int'(ptr_q) + i) % NUM_REQ);
            if (!win_vld && req_valid[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin : p_next
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_idx_d = grant_idx_q;
        hold_data_d = hold_data_q;
        hold_keep_d = hold_keep_q;
        hold_cnt_d  = hold_cnt_q;
        req_ready   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (win_vld && rst_n) begin
                    req_ready[win_idx] = 1'b1;
                    hold_data_d = req_data[win_idx*DATA_WD +: DATA_WD];
                    hold_keep_d = req_keep[win_idx*DATA_BYTE_WD +: DATA_BYTE_WD];
                    hold_cnt_d  = req_byte_cnt[win_idx*BYTE_CNT_WD +: BYTE_CNT_WD];
                    ptr_d       = win_idx;
                    grant_idx_d = win_idx;
                    state_d     = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (ready_insert) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (pkt_end) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (wdog_hit) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: holding registers are reset too, so data/keep/count outputs read 0 after reset.
            state_q     <= ST_IDLE;
            ptr_q       <= REQ_IDX_WD'(NUM_REQ - 1);
            grant_idx_q <= '0;
            hold_data_q <= '0;
            hold_keep_q <= '0;
            hold_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all state updates simultaneous at the edge.
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_idx_q <= grant_idx_d;
            hold_data_q <= hold_data_d;
            hold_keep_q <= hold_keep_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

`ifdef HDR_ARB_WDOG_EN
    localparam int CNT_WD = (WDOG_CYC > 2) ? $clog2(WDOG_CYC) : 1;

    logic [CNT_WD-1:0] wdog_cnt_q, wdog_cnt_d;

    assign wdog_hit = (state_q != ST_IDLE) && (wdog_cnt_q == CNT_WD'(WDOG_CYC - 1));

    always_comb begin : p_wdog
        wdog_cnt_d = wdog_cnt_q + 1'b1;
        if (state_q == ST_IDLE || state_d != state_q || out_beat) wdog_cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wdog_cnt_q <= '0;
        else        wdog_cnt_q <= wdog_cnt_d;
    end

    assign wdog_err = wdog_hit;
`else
    assign wdog_hit = 1'b0;
    assign wdog_err = 1'b0;
`endif

    assign valid_insert    = (state_q == ST_OFFER);
    assign grant_vld       = (state_q != ST_IDLE);
    assign grant_idx       = grant_idx_q;
    assign data_insert     = hold_data_q;
    assign keep_insert     = hold_keep_q;
    assign byte_insert_cnt = hold_cnt_q;

endmodule
